// File: rtl/serial_frame_deser.sv
// Start/stop serial deframer, LSB first, into a 2-entry registered valid/ready FIFO; word visible the cycle after its stop bit.
// Define SERIAL_FRAME_DESER_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.
module serial_frame_deser #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_vld,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic             frame_err,
  output logic             ovf,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_PAR  = 2'd2,
    S_STOP = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_frame_err;
  logic             r_ovf;

  logic [WIDTH-1:0] r_head;
  logic             r_head_vld;
  logic [WIDTH-1:0] r_tail;
  logic             r_tail_vld;

  logic w_last_bit;
  logic w_stop_take;
  logic w_par_err;
  logic w_push;
  logic w_pop;
  logic w_frame_bad;

  assign w_last_bit  = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_stop_take = (r_state == S_STOP) && sin_vld;
  assign w_push      = w_stop_take && sin && !w_par_err;
  // A bad stop bit and a bad parity bit both end in a single error pulse.
  assign w_frame_bad = w_stop_take && (!sin || w_par_err);
  assign w_pop       = r_head_vld && dout_rdy;

`ifdef SERIAL_FRAME_DESER_PARITY_EN
  logic r_par_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_par_err <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_par_err <= 1'b0;
    end else if (r_state == S_PAR && sin_vld) begin
      r_par_err <= (^r_shift) ^ sin;
    end
  end

  assign w_par_err = r_par_err;
`else
  assign w_par_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        // A high line is idle; only a sampled 0 opens a frame.
        if (sin_vld && !sin) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (sin_vld && w_last_bit) begin
`ifdef SERIAL_FRAME_DESER_PARITY_EN
          w_state_nxt = S_PAR;
`else
          w_state_nxt = S_STOP;
`endif
        end
      end
      S_PAR: begin
        if (sin_vld) begin
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (sin_vld) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_frame_bad;
      unique case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
        end
        S_DATA: begin
          if (sin_vld) begin
            r_shift <= {sin, r_shift[WIDTH-1:1]};
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (sin_vld) begin
            r_cnt <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Head register drives dout directly; tail holds the second word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head     <= '0;
      r_head_vld <= 1'b0;
      r_tail     <= '0;
      r_tail_vld <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_ovf <= 1'b0;
      unique case ({w_push, w_pop})
        2'b11: begin
          if (r_tail_vld) begin
            r_head <= r_tail;
            r_tail <= r_shift;
          end else begin
            r_head <= r_shift;
          end
        end
        2'b10: begin
          if (!r_head_vld) begin
            r_head     <= r_shift;
            r_head_vld <= 1'b1;
          end else if (!r_tail_vld) begin
            r_tail     <= r_shift;
            r_tail_vld <= 1'b1;
          end else begin
            r_ovf <= 1'b1;
          end
        end
        2'b01: begin
          if (r_tail_vld) begin
            r_head     <= r_tail;
            r_tail     <= '0;
            r_tail_vld <= 1'b0;
          end else begin
            r_head     <= '0;
            r_head_vld <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign dout      = r_head;
  assign dout_vld  = r_head_vld;
  assign frame_err = r_frame_err;
  assign ovf       = r_ovf;
  assign busy      = (r_state != S_IDLE);

endmodule
